booth_mult_arbiter: RTL and testbench
=====================================

BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the signed operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each, meaning requester i presents an operand pair.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1 each, meaning requester i's pair is accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, N each, as signed two's-complement multiplicand and multiplier.
REQ-007 The block SHALL have port resp_valid, output, 1, meaning a product is presented.
REQ-008 The block SHALL have port resp_ready, input, 1, meaning the consumer accepts the product.
REQ-009 The block SHALL have port resp_id, output, 1, giving the requester index that owns the product.
REQ-010 The block SHALL have port resp_product, output, 2N, giving the signed product a*b.
REQ-011 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement states IDLE, RUN and DONE.
REQ-013 In IDLE, reqi_ready SHALL be high only for the granted requester and SHALL be low in RUN and DONE.
REQ-014 Grant SHALL go to the only valid requester; if both are valid, it SHALL go to the one not served last (round-robin).
REQ-015 A transfer SHALL occur on valid&ready; it SHALL latch a, b and the id, and clear the accumulator and Q-1 bit.
REQ-016 If a==0 or b==0 at acceptance, the block SHALL go IDLE->DONE with product 0, so resp_valid is high 1 cycle after acceptance.
REQ-017 Otherwise the block SHALL go IDLE->RUN for exactly N cycles, retiring one radix-2 Booth step per cycle.
REQ-018 Each Booth step SHALL examine the pair {multiplier bit i, previous bit}: 10 subtracts the multiplicand from the upper half, 01 adds it, 00/11 does nothing, then an arithmetic right shift by one follows.
REQ-019 The accumulator SHALL be N+1 bits wide so that a = -2^(N-1) or b = -2^(N-1) yields the exact product with no post-correction.
REQ-020 After the Nth step the block SHALL go RUN->DONE, so resp_valid rises N+1 cycles after acceptance.
REQ-021 In DONE, resp_valid, resp_id and resp_product SHALL stay stable until resp_ready is sampled high.
REQ-022 On the handshake, the block SHALL go DONE->IDLE and update last-served to resp_id.
REQ-023 A new request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-024 Input operand changes after acceptance SHALL NOT affect the result in flight.
REQ-025 resp_product SHALL equal the signed product modulo nothing, i.e. an exact 2N-bit result for all input pairs.
REQ-026 If resp_valid is low, resp_product and resp_id SHALL hold their last values.

Reset
REQ-027 When rst_n is low, the block SHALL asynchronously force state IDLE, resp_valid 0, resp_product 0, resp_id 0, busy 0, step counter 0 and last-served 1 (so req0 wins the first tie).
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation with no response, and the block SHALL resume accepting requests from IDLE after rst_n is released.

Verification
REQ-029 With N=32, req0 sends a=7, b=-3: resp_valid at acceptance+33, resp_id=0, resp_product=-21 (0xFFFFFFFFFFFFFFEB).
REQ-030 Both valid in the same cycle after reset: req0 is served first; req1 is accepted in the cycle after req0's response handshake, and ids arrive in the order 0 then 1.
REQ-031 req1 sends a=b=-2^31: resp_product=0x4000000000000000. With a=-2^31, b=1: resp_product=0xFFFFFFFF80000000.
REQ-032 req0 sends a=0, b=12345: resp_valid 1 cycle after acceptance, resp_product=0, busy high for exactly 1 cycle before DONE.
REQ-033 Hold resp_ready=0 for 10 cycles in DONE: resp_valid and resp_product stay stable, both readies stay 0, and the block goes IDLE the cycle after resp_ready=1.
REQ-034 Assert rst_n=0 at RUN step 15: all outputs go to reset values immediately and no response is emitted; a fresh 5*6 request afterwards returns 30.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Two-requester round-robin front end feeding a sequential radix-2 Booth multiplier.
// One signed N x N product is computed at a time and held until the consumer takes it.
module booth_mult_arbiter #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [2*N-1:0] resp_product,
  output logic           busy
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N:0]       acc_q, acc_d;
  logic [N-1:0]     mq_q, mq_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [2*N-1:0]   prod_q, prod_d;
  logic             busy_q, busy_d;

  logic             gnt0, gnt1;
  logic [N-1:0]     a_sel, b_sel;
  logic [N:0]       m_ext, sum, acc_sh;
  logic [N-1:0]     mq_sh;

  // On a tie, the requester not served last wins.
  assign gnt0 = req0_valid && (!req1_valid || last_q);
  assign gnt1 = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;
  assign a_sel = gnt1 ? req1_a : req0_a;
  assign b_sel = gnt1 ? req1_b : req0_b;

  // The extra accumulator bit absorbs 0 - (-2^(N-1)) without overflow.
  assign m_ext = {m_q[N-1], m_q};
  always_comb begin
    sum = acc_q;
    case ({mq_q[0], qm1_q})
      2'b10:   sum = acc_q - m_ext;
      2'b01:   sum = acc_q + m_ext;
      default: sum = acc_q;
    endcase
  end
  assign acc_sh = {sum[N], sum[N:1]};
  assign mq_sh  = {sum[0], mq_q[N-1:1]};

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    acc_d        = acc_q;
    mq_d         = mq_q;
    qm1_d        = qm1_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_d       = last_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    prod_d       = prod_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          m_d     = a_sel;
          mq_d    = b_sel;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          owner_d = gnt1;
          busy_d  = 1'b1;
          if (a_sel == '0 || b_sel == '0) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_id_d    = gnt1;
            prod_d       = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = acc_sh;
        mq_d  = mq_sh;
        qm1_d = mq_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_id_d    = owner_q;
          prod_d       = {acc_sh[N-1:0], mq_sh};
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          busy_d       = 1'b0;
          last_d       = resp_id_q;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      m_q          <= '0;
      acc_q        <= '0;
      mq_q         <= '0;
      qm1_q        <= 1'b0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      prod_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      acc_q        <= acc_d;
      mq_q         <= mq_d;
      qm1_q        <= qm1_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      prod_q       <= prod_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = prod_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed-vector bench for booth_mult_arbiter with N=32 and hand-computed products.
module tb_booth_mult_arbiter;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [N-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          resp_valid, resp_id, busy;
  logic          resp_ready = 1'b0;
  logic [2*N-1:0] resp_product;

  int vectors = 0;
  int errs = 0;

  booth_mult_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_product(resp_product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Waits for resp_valid starting one cycle after acceptance; returns cycles elapsed.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int lat;
    logic [63:0] p;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    lat = 0;
    while (!(id ? req1_ready : req0_ready) && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    chk("accept", 64'(id ? req1_ready : req0_ready), 64'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEAD_BEEF; req0_b = 32'h1234_5678;
    req1_a = 32'hCAFE_F00D; req1_b = 32'h0BAD_0BAD;
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_resp(lat);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("resp_id", 64'(resp_id), 64'(id));
    chk("product", resp_product, exp);
    p = resp_product;
    if (hold > 0) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_product", resp_product, p);
      chk("hold_readies", 64'({req0_ready, req1_ready}), 64'd0);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("valid_cleared", 64'(resp_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("product_kept", resp_product, p);
  endtask

  initial begin
    int lat;
    // Reset state
    #12;
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", resp_product, 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tie after reset: req0 first, req1 accepted right after the handshake
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
    req1_valid = 1'b1; req1_a = -32'sd5; req1_b = 32'd6;
    #1;
    chk("tie_r0_ready", 64'(req0_ready), 64'd1);
    chk("tie_r1_ready", 64'(req1_ready), 64'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("tie_r1_blocked", 64'(req1_ready), 64'd0);
    wait_resp(lat);
    chk("tie_lat0", 64'(lat), 64'd33);
    chk("tie_id0", 64'(resp_id), 64'd0);
    chk("tie_prod0", resp_product, 64'd12);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("tie_r1_ready_next", 64'(req1_ready), 64'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(lat);
    chk("tie_lat1", 64'(lat), 64'd33);
    chk("tie_id1", 64'(resp_id), 64'd1);
    chk("tie_prod1", resp_product, 64'hFFFF_FFFF_FFFF_FFE2);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    run_op(1'b0, 32'd7, -32'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 33, 10);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 33, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 33, 0);
    run_op(1'b0, 32'd0, 32'd12345, 64'd0, 1, 0);
    run_op(1'b1, 32'd12345, 32'd0, 64'd0, 1, 0);
    run_op(1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 33, 0);

    // Reset mid-run aborts with no response
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("midrun_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(resp_valid), 64'd0);
    chk("abort_product", resp_product, 64'd0);
    chk("abort_id", 64'(resp_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_resp_after_abort", 64'(resp_valid), 64'd0);
    run_op(1'b0, 32'd5, 32'd6, 64'd30, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
